// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter with a parallel load, built from one JK flip-flop per bit.
// The state changes on the falling edge of iClk. iReset clears the count asynchronously.
`timescale 1ns/1ps

module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end
endmodule

module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iEn,
  input  logic             iUp,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iD,
  output logic [WIDTH-1:0] oQ,
  output logic             oTC,
  output logic             oWrap
);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (q == MAX_Q);
  assign at_zero = (q == '0);

  // A wrap happens exactly when the terminal count is reached on an enabled, non-load edge.
  assign oTC = iEn & ~iLoad & ((iUp & at_max) | (~iUp & at_zero));

  always_comb begin
    nxt = q;
    if (iLoad) begin
      nxt = ({1'b0, iD} < MOD_W) ? iD : '0;
    end else if (iEn) begin
      if (iUp) begin
        nxt = at_max ? '0 : q + 1'b1;
      end else begin
        nxt = at_zero ? MAX_Q : q - 1'b1;
      end
    end
  end

  // Excitation: set the bits that rise, clear the bits that fall, hold the rest.
  assign j = nxt & ~q;
  assign k = ~nxt & q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff u_ff (
      .clk (iClk),
      .rst (iReset),
      .j   (j[i]),
      .k   (k[i]),
      .q   (q[i])
    );
  end

  always_ff @(negedge iClk or posedge iReset) begin
    if (iReset) begin
      oWrap <= 1'b0;
    end else begin
      oWrap <= oTC;
    end
  end

  assign oQ = q;
endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter. It checks a modulus-10 instance and a modulus-16 instance.
`timescale 1ns/1ps

module tb_jk_mod_counter;
  logic       clk = 1'b1;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] d;
  logic [3:0] qa;
  logic [3:0] qb;
  logic       tca;
  logic       tcb;
  logic       wrapa;
  logic       wrapb;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #2.5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut_a (
    .iClk(clk), .iReset(rst), .iEn(en), .iUp(up), .iLoad(load), .iD(d),
    .oQ(qa), .oTC(tca), .oWrap(wrapa)
  );

  jk_mod_counter #(.WIDTH(4), .MODULUS(16)) u_dut_b (
    .iClk(clk), .iReset(rst), .iEn(en), .iUp(up), .iLoad(load), .iD(d),
    .oQ(qb), .oTC(tcb), .oWrap(wrapb)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; d = 4'd0;
    #1;
    check("rst_q", qa, 0);
    check("rst_wrap", wrapa, 0);
    check("rst_tc_up", tca, 0);
    up = 1'b0;
    #1;
    check("rst_tc_down", tca, 1);
    up = 1'b1;
    #4;
    check("rst_q_after_edge", qa, 0);
    #11;
    rst = 1'b0;

    // The first falling edge after release is at 17.5 ns.
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("up_q_%0d", i), qa, i % 10);
      check($sformatf("up_tc_%0d", i), tca, (i == 9) ? 1 : 0);
      check($sformatf("up_wrap_%0d", i), wrapa, (i == 10) ? 1 : 0);
    end
    step();
    check("up_q_after_wrap", qa, 1);
    check("up_wrap_clear", wrapa, 0);

    up = 1'b0;
    step();
    check("dn_q0", qa, 0);
    check("dn_tc0", tca, 1);
    check("dn_wrap0", wrapa, 0);
    step();
    check("dn_q9", qa, 9);
    check("dn_wrap9", wrapa, 1);
    check("dn_tc9", tca, 0);
    step();
    check("dn_q8", qa, 8);
    check("dn_wrap8", wrapa, 0);
    step();
    check("dn_q7", qa, 7);

    load = 1'b1; d = 4'd6;
    step();
    check("ld6_q", qa, 6);
    check("ld6_wrap", wrapa, 0);
    check("ld6_tc", tca, 0);
    d = 4'd12;
    step();
    check("ld12_q", qa, 0);
    check("ld12_wrap", wrapa, 0);
    check("ld_tc_masked", tca, 0);
    d = 4'd9;
    step();
    check("ld9_q", qa, 9);
    check("ld9_wrap", wrapa, 0);
    up = 1'b1; d = 4'd0;
    step();
    check("ld0_q", qa, 0);
    check("ld0_wrap", wrapa, 0);

    d = 4'd4;
    step();
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      up = ~up;
      step();
      check($sformatf("hold_q_%0d", i), qa, 4);
      check($sformatf("hold_tc_%0d", i), tca, 0);
      check($sformatf("hold_wrap_%0d", i), wrapa, 0);
    end

    load = 1'b1; d = 4'd7;
    step();
    check("pre_rst_q", qa, 7);
    load = 1'b0; en = 1'b1; up = 1'b1;
    #0.5 rst = 1'b1;
    #0.5;
    check("async_rst_q", qa, 0);
    check("async_rst_wrap", wrapa, 0);
    #0.5 rst = 1'b0;
    step();
    check("resume_q", qa, 1);

    load = 1'b1; d = 4'd15;
    step();
    check("b_ld15_q", qb, 15);
    check("a_ld15_q", qa, 0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    #0.1;
    check("b_tc15", tcb, 1);
    step();
    check("b_wrap_up_q", qb, 0);
    check("b_wrap_up", wrapb, 1);
    check("a_no_wrap", wrapa, 0);
    up = 1'b0;
    #0.1;
    check("b_tc0_down", tcb, 1);
    step();
    check("b_wrap_dn_q", qb, 15);
    check("b_wrap_dn", wrapb, 1);
    check("b_tc15_down", tcb, 0);
    step();
    check("b_q14", qb, 14);
    check("b_wrap_clear", wrapb, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
